// File: rtl/buzzer_pkg.sv
// buzzer_pkg: shared state encodings and 100 MHz default delays for the buzzer round logic.
package buzzer_pkg;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMING  = 3'd1;
  localparam logic [2:0] ST_ARMED   = 3'd2;
  localparam logic [2:0] ST_LOCKED  = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;
  localparam int ARM_DELAY_100MHZ = 300_000_000;
  localparam int TIMEOUT_100MHZ   = 500_000_000;
endpackage

// File: rtl/buzzer_round_arbiter_rr_priority_pick.sv
// rr_priority_pick: combinational rotating-priority pick of the first request at or after ptr.
module rr_priority_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic            o_gnt_valid,
  output logic [ID_W-1:0] o_gnt_id,
  output logic [N-1:0]    o_gnt_onehot
);
  int w_idx;
  always_comb begin
    w_idx = 0;
    o_gnt_valid = |i_req;
    o_gnt_id = '0;
    // scan farthest offset first so the closest request to ptr is the last assignment
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (i_req[w_idx]) o_gnt_id = ID_W'(w_idx);
    end
    o_gnt_onehot = o_gnt_valid ? N'(1) << o_gnt_id : '0;
  end
endmodule

// File: rtl/buzzer_round_arbiter.sv
// buzzer_round_arbiter: round FSM for N buzzers with false-start lockout, timeout and
// rotating priority between same-cycle presses.
module buzzer_round_arbiter
  import buzzer_pkg::*;
#(
  parameter int N_PLAYERS      = 4,
  parameter int ID_W           = 2,
  parameter int CNT_W          = 32,
  parameter int ARM_DELAY      = ARM_DELAY_100MHZ,
  parameter int TIMEOUT_CYCLES = TIMEOUT_100MHZ
) (
  input  logic                 clock_100Mhz,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic                 i_clear,
  input  logic [N_PLAYERS-1:0] i_press,
  output logic                 o_armed,
  output logic                 o_winner_valid,
  output logic [ID_W-1:0]      o_winner_id,
  output logic [N_PLAYERS-1:0] o_winner_onehot,
  output logic [N_PLAYERS-1:0] o_false_start,
  output logic                 o_timeout
);
  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [N_PLAYERS-1:0] r_false_start;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [ID_W-1:0]      r_winner_id;
  logic [N_PLAYERS-1:0] w_eligible;
  logic                 w_gnt_valid;
  logic [ID_W-1:0]      w_gnt_id;
  logic [N_PLAYERS-1:0] w_gnt_onehot;
  logic                 w_arm_done;
  logic                 w_time_done;

  assign w_eligible  = i_press & ~r_false_start;
  assign w_arm_done  = r_cnt == CNT_W'(ARM_DELAY - 1);
  assign w_time_done = r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);

  rr_priority_pick #(.N(N_PLAYERS), .ID_W(ID_W)) u_pick (
    .i_req       (w_eligible),
    .i_ptr       (r_rr_ptr),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id),
    .o_gnt_onehot(w_gnt_onehot)
  );

  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_false_start <= '0;
      r_rr_ptr      <= '0;
      r_winner_id   <= '0;
    end else if (i_clear) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_false_start <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_LOCKED, ST_TIMEOUT: if (i_start) begin
          r_state       <= ST_ARMING;
          r_cnt         <= '0;
          r_false_start <= '0;
        end
        ST_ARMING: begin
          r_false_start <= r_false_start | i_press;
          r_cnt         <= w_arm_done ? '0 : r_cnt + 1'b1;
          if (w_arm_done) r_state <= ST_ARMED;
        end
        ST_ARMED: if (w_gnt_valid) begin
          r_state     <= ST_LOCKED;
          r_cnt       <= '0;
          r_winner_id <= w_gnt_id;
          r_rr_ptr    <= ID_W'((int'(w_gnt_id) + 1) % N_PLAYERS);
        end else begin
          r_cnt <= w_time_done ? '0 : r_cnt + 1'b1;
          if (w_time_done) r_state <= ST_TIMEOUT;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_armed         = r_state == ST_ARMED;
  assign o_winner_valid  = r_state == ST_LOCKED;
  assign o_timeout       = r_state == ST_TIMEOUT;
  assign o_winner_id     = o_winner_valid ? r_winner_id : '0;
  assign o_winner_onehot = o_winner_valid ? N_PLAYERS'(1) << r_winner_id : '0;
  assign o_false_start   = r_false_start;
endmodule

// File: tb/tb_buzzer_round_arbiter.sv
// tb_buzzer_round_arbiter: directed rounds with a scoreboard of expected round outcomes.
module tb_buzzer_round_arbiter;
  logic       clk = 0;
  logic       reset = 0;
  logic       start = 0;
  logic       clear = 0;
  logic [3:0] press = 0;
  logic       o_armed, o_winner_valid, o_timeout;
  logic [1:0] o_winner_id;
  logic [3:0] o_winner_onehot, o_false_start;

  typedef struct {bit to; int id; logic [3:0] fs; int cyc;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic p_armed = 0, p_wv = 0, p_to = 0;

  buzzer_round_arbiter #(.N_PLAYERS(4), .ID_W(2), .CNT_W(8), .ARM_DELAY(4), .TIMEOUT_CYCLES(8)) dut (
    .clock_100Mhz   (clk),
    .reset          (reset),
    .i_start        (start),
    .i_clear        (clear),
    .i_press        (press),
    .o_armed        (o_armed),
    .o_winner_valid (o_winner_valid),
    .o_winner_id    (o_winner_id),
    .o_winner_onehot(o_winner_onehot),
    .o_false_start  (o_false_start),
    .o_timeout      (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {19'd0, o_armed, o_winner_valid, o_winner_id, o_winner_onehot, o_false_start, o_timeout};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (o_armed === 1'b1 && p_armed !== 1'b1) cyc = 0;
    else cyc++;
    if ((o_winner_valid === 1'b1 && p_wv !== 1'b1) || (o_timeout === 1'b1 && p_to !== 1'b1)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_outcome: wv=%0b to=%0b id=%0d with empty scoreboard", o_winner_valid, o_timeout, o_winner_id);
      end else begin
        e = q.pop_front();
        chk("timeout", 32'(o_timeout), 32'(e.to));
        chk("winner_valid", 32'(o_winner_valid), 32'(!e.to));
        chk("winner_id", 32'(o_winner_id), e.to ? 0 : e.id);
        chk("winner_onehot", 32'(o_winner_onehot), e.to ? 0 : 32'(1) << e.id);
        chk("false_start", 32'(o_false_start), 32'(e.fs));
        chk("armed_low", 32'(o_armed), 0);
        chk("latency_from_armed", cyc, e.cyc);
      end
    end
    p_armed = o_armed;
    p_wv = o_winner_valid;
    p_to = o_timeout;
  end

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic wait_armed();
    int n = 0;
    while (o_armed !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (o_armed !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_armed: armed never rose within 40 cycles");
    end
  endtask

  task automatic armed_win(input logic [3:0] p, input int id, input logic [3:0] fs, input int delay);
    wait_armed();
    repeat (delay) @(negedge clk);
    press = p;
    q.push_back('{0, id, fs, delay + 1});
    @(negedge clk) press = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic armed_timeout(input logic [3:0] fs);
    wait_armed();
    q.push_back('{1, 0, fs, 8});
    repeat (10) @(negedge clk);
  endtask

  initial begin
    press = 4'b1111;
    start = 1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    reset = 1;
    start = 0;
    press = 0;
    @(negedge clk);
    chk("post_reset_outputs", outs(), 0);
    pulse_start();
    armed_win(4'b0100, 2, 4'b0000, 0);
    pulse_start();
    press = 4'b0001;
    @(negedge clk) press = 0;
    armed_win(4'b0011, 1, 4'b0001, 0);
    pulse_start();
    armed_win(4'b0100, 2, 4'b0000, 0);
    pulse_start();
    armed_win(4'b1001, 3, 4'b0000, 0);
    pulse_start();
    armed_win(4'b1001, 0, 4'b0000, 0);
    pulse_start();
    armed_timeout(4'b0000);
    pulse_start();
    armed_win(4'b0010, 1, 4'b0000, 7);
    pulse_start();
    press = 4'b1111;
    armed_timeout(4'b1111);
    press = 0;
    pulse_start();
    wait_armed();
    repeat (2) @(negedge clk);
    clear = 1;
    @(negedge clk) clear = 0;
    chk("clear_idle_outputs", outs(), 0);
    pulse_start();
    @(negedge clk) reset = 0;
    @(negedge clk) reset = 1;
    chk("reset_mid_arming_outputs", outs(), 0);
    pulse_start();
    armed_win(4'b1111, 0, 4'b0000, 0);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end
endmodule
